fft_in_pair_sched: RTL

//  Sequencer for the FFT input pair register (Reg_in datapath). Accepts one input frame
//  (a1,a2,b1,b2) per valid/ready handshake and pulses the register load enable.
//  It then walks the pair address 0..NUM_PAIRS-1, offering each {b,a} pair to the

---
 rtl/fft_pkg.sv | 17 +
 rtl/fft_sat_counter.sv | 33 +++
 rtl/fft_in_pair_sched.sv | 101 ++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// Shared definitions for the FFT input-pair sequencer: FSM state encoding,
// pair-count helper and the default statistics counter width.
package fft_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_e;

    localparam int STAT_W_DEF = 16;

    // One pair per (a,b) combination of complex words.
    function automatic int num_pairs(input int no_comp_word);
        return no_comp_word * no_comp_word;
    endfunction

endpackage

// File: rtl/fft_sat_counter.sv
// Event counter that either saturates at all-ones or wraps modulo 2**W.
// Cleared only by the asynchronous active-low reset.
module fft_sat_counter #(
    parameter int W        = 16,
    parameter bit SATURATE = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && !(SATURATE && (&cnt_q))) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/fft_in_pair_sched.sv
// Sequencer for the FFT input pair register: accepts a frame, then walks addr
// over every {b,a} pair. Statistics counters exist only with FFT_SEQ_STATS_EN.
module fft_in_pair_sched
    import fft_pkg::*;
#(
    parameter int NO_comp_word = 2,
    parameter int data_width   = 8,
    parameter int STAT_W       = STAT_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic                    load_en,
    output logic [NO_comp_word-1:0] addr,
    output logic                    pair_valid,
    input  logic                    pair_ready,
    output logic                    pair_last,
    output logic                    busy,
    output logic [STAT_W-1:0]       frame_cnt,
    output logic [STAT_W-1:0]       stall_cnt
);

    localparam int NUM_PAIRS = num_pairs(NO_comp_word);
    localparam logic [NO_comp_word-1:0] LAST_ADDR = NO_comp_word'(NUM_PAIRS - 1);

    if (NUM_PAIRS > (1 << NO_comp_word) || data_width < 1) begin : g_cfg_err
        $error("fft_in_pair_sched: unsupported NO_comp_word/data_width");
    end

    state_e                  state_q;
    logic [NO_comp_word-1:0] addr_q;

    // Flush outranks every transition; addr only moves on an accepted pair.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
        end else if (flush) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        state_q <= ST_ISSUE;
                        addr_q  <= '0;
                    end
                end
                ST_ISSUE: begin
                    if (pair_ready) begin
                        if (addr_q == LAST_ADDR) begin
                            state_q <= ST_IDLE;
                            addr_q  <= '0;
                        end else begin
                            addr_q <= addr_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    addr_q  <= '0;
                end
            endcase
        end
    end

    assign busy       = (state_q != ST_IDLE);
    assign pair_valid = (state_q == ST_ISSUE);
    assign addr       = addr_q;
    assign pair_last  = pair_valid && (addr_q == LAST_ADDR);
    assign in_ready   = (state_q == ST_IDLE) && !flush;
    assign load_en    = in_valid && in_ready;

`ifdef FFT_SEQ_STATS_EN
    logic frame_done;
    logic stall_evt;

    assign frame_done = pair_last && pair_ready && !flush;
    assign stall_evt  = pair_valid && !pair_ready;

    fft_sat_counter #(.W(STAT_W), .SATURATE(1'b0)) u_frame_cnt (
        .clk (clk),
        .rst (rst),
        .inc (frame_done),
        .cnt (frame_cnt)
    );

    fft_sat_counter #(.W(STAT_W), .SATURATE(1'b1)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (stall_evt),
        .cnt (stall_cnt)
    );
`else
    assign frame_cnt = '0;
    assign stall_cnt = '0;
`endif

endmodule
